// File: rtl/int_disp_router_pkg.sv
// Shared integer-core definitions: micro-op layout, issue-queue IDs and the
// ID-to-index mapping used by the integer dispatch router.
package int_disp_router_pkg;

  localparam int DISP_WID_P   = 4;
  localparam int IQ_NUM_P     = 4;
  localparam int IQ_DEPTH_P   = 16;
  localparam int IQ_ENQ_WID_P = 2;
  localparam int CW_P         = $clog2(IQ_DEPTH_P + 1);
  localparam int IQ_ID_W      = 3;

  localparam logic [IQ_ID_W-1:0] ALU_IQ_ID = 3'd0;
  localparam logic [IQ_ID_W-1:0] BRU_IQ_ID = 3'd1;
  localparam logic [IQ_ID_W-1:0] MDU_IQ_ID = 3'd2;
  localparam logic [IQ_ID_W-1:0] SCU_IQ_ID = 3'd3;

  typedef struct packed {
    logic [IQ_ID_W-1:0] issueQueId;
    logic [7:0]         robIdx;
    logic [19:0]        imm;
  } microOp_t;

  function automatic logic iq_id_valid(input logic [IQ_ID_W-1:0] id);
    case (id)
      ALU_IQ_ID, BRU_IQ_ID, MDU_IQ_ID, SCU_IQ_ID: iq_id_valid = 1'b1;
      default:                                    iq_id_valid = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] iq_id_to_idx(input logic [IQ_ID_W-1:0] id);
    case (id)
      ALU_IQ_ID: iq_id_to_idx = 2'd0;
      BRU_IQ_ID: iq_id_to_idx = 2'd1;
      MDU_IQ_ID: iq_id_to_idx = 2'd2;
      SCU_IQ_ID: iq_id_to_idx = 2'd3;
      default:   iq_id_to_idx = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/int_disp_router_if.sv
// Dispatch-head / issue-queue bundle seen by the integer dispatch router.
// slave = router side, master = dispatch queue plus issue queues.
interface int_disp_router_if
  import int_disp_router_pkg::*;
#(
  parameter int DISP_WID   = DISP_WID_P,
  parameter int IQ_NUM     = IQ_NUM_P,
  parameter int IQ_ENQ_WID = IQ_ENQ_WID_P,
  parameter int CW         = CW_P
);
  logic                                    i_squash_vld;
  logic [DISP_WID-1:0]                     i_disp_req;
  microOp_t [DISP_WID-1:0]                 i_disp_info;
  logic [DISP_WID-1:0]                     o_disp_rdy;
  logic [IQ_NUM-1:0][IQ_ENQ_WID-1:0]       o_iq_enq_vld;
  microOp_t [IQ_NUM-1:0][IQ_ENQ_WID-1:0]   o_iq_enq_info;
  logic [IQ_NUM-1:0][CW-1:0]               i_iq_deq_cnt;

  modport slave (
    input  i_squash_vld, i_disp_req, i_disp_info, i_iq_deq_cnt,
    output o_disp_rdy, o_iq_enq_vld, o_iq_enq_info
  );

  modport master (
    output i_squash_vld, i_disp_req, i_disp_info, i_iq_deq_cnt,
    input  o_disp_rdy, o_iq_enq_vld, o_iq_enq_info
  );
endinterface

// File: rtl/int_disp_router_chk.sv
// Simulation checks for the integer dispatch router.
module int_disp_router_chk #(
  parameter int DISP_WID = 4,
  parameter int IQ_NUM   = 4,
  parameter int IQ_DEPTH = 16,
  parameter int CW       = 5
) (
  input logic                      clk,
  input logic                      rst,
  input logic                      squash_i,
  input logic [DISP_WID-1:0]       bad_id_i,
  input logic [DISP_WID-1:0]       rdy_i,
  input logic [IQ_NUM-1:0][CW-1:0] credit_i,
  input logic [IQ_NUM-1:0][CW-1:0] enq_cnt_i,
  input logic [IQ_NUM-1:0][CW-1:0] deq_cnt_i
);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(IQ_DEPTH);

  logic [DISP_WID-1:0] rdy_inc_s;
  assign rdy_inc_s = rdy_i + DISP_WID'(1);

  a_rdy_prefix: assert property (@(posedge clk) disable iff (rst) (rdy_i & rdy_inc_s) == '0);
  a_iq_id_range: assert property (@(posedge clk) disable iff (rst) bad_id_i == '0);

  for (genvar q = 0; q < IQ_NUM; q++) begin : g_cred_chk
    a_credit_max: assert property (@(posedge clk) disable iff (rst || squash_i)
      ({1'b0, credit_i[q]} - {1'b0, enq_cnt_i[q]} + {1'b0, deq_cnt_i[q]}) <= DEPTH_W);
  end
endmodule

// File: rtl/int_disp_router_iq_credit_ctr.sv
// Free-entry credit counter for one issue queue; flush restores full credit.
module iq_credit_ctr #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic [CW-1:0] enq_cnt_i,
  input  logic [CW-1:0] deq_cnt_i,
  output logic [CW-1:0] credit_o
);
  logic [CW-1:0] credit_q;
  logic [CW-1:0] credit_d;

  // Next credit: enqueues and frees of the same cycle land together.
  always_comb begin
    credit_d = credit_q;
    if (flush_i) begin
      credit_d = CW'(DEPTH);
    end else begin
      credit_d = credit_q - enq_cnt_i + deq_cnt_i;
    end
  end

  // Credit register.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_q <= CW'(DEPTH);
    end else begin
      credit_q <= credit_d;
    end
  end

  assign credit_o = credit_q;
endmodule

// File: rtl/int_disp_router.sv
// Integer dispatch router: in-order prefix accept against per-IQ credit, one-cycle
// registered hand-off to the issue queues. Option: INT_DISP_ROUTER_PERF_EN adds stall counters.
module int_disp_router
  import int_disp_router_pkg::*;
#(
  parameter int DISP_WID   = DISP_WID_P,
  parameter int IQ_NUM     = IQ_NUM_P,
  parameter int IQ_DEPTH   = IQ_DEPTH_P,
  parameter int IQ_ENQ_WID = IQ_ENQ_WID_P
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef INT_DISP_ROUTER_PERF_EN
  output logic [63:0]             o_perf_stall_cycles,
  output logic [IQ_NUM-1:0][63:0] o_perf_iq_full,
`endif
  int_disp_router_if.slave        bus
);
  localparam int CW = $clog2(IQ_DEPTH + 1);
  localparam int QW = $clog2(IQ_NUM);
  localparam int NW = $clog2(IQ_ENQ_WID + 1);
  localparam int EW = (IQ_ENQ_WID > 1) ? $clog2(IQ_ENQ_WID) : 1;

  logic [DISP_WID-1:0]                   rdy_s;
  logic [DISP_WID-1:0]                   bad_id_s;
  logic [IQ_NUM-1:0][NW-1:0]             n_s;
  logic [IQ_NUM-1:0][CW-1:0]             enq_cnt_s;
  logic [IQ_NUM-1:0][CW-1:0]             credit_s;
  logic [QW-1:0]                         qi_s;
  logic                                  ok_s;
  logic [IQ_NUM-1:0][IQ_ENQ_WID-1:0]     enq_vld_d, enq_vld_q;
  microOp_t [IQ_NUM-1:0][IQ_ENQ_WID-1:0] enq_info_d, enq_info_q;

  // Walk the head oldest-first; the first refusal closes the prefix, and
  // n_s doubles as the next free port index of each queue.
  always_comb begin
    rdy_s      = '0;
    bad_id_s   = '0;
    n_s        = '0;
    enq_vld_d  = '0;
    enq_info_d = '0;
    qi_s       = '0;
    ok_s       = 1'b1;
    for (int i = 0; i < DISP_WID; i++) begin
      qi_s        = iq_id_to_idx(bus.i_disp_info[i].issueQueId);
      bad_id_s[i] = bus.i_disp_req[i] & ~iq_id_valid(bus.i_disp_info[i].issueQueId);
      if (ok_s && bus.i_disp_req[i] && !bad_id_s[i] && !bus.i_squash_vld &&
          (n_s[qi_s] < NW'(IQ_ENQ_WID)) && (CW'(n_s[qi_s]) < credit_s[qi_s])) begin
        rdy_s[i]                              = 1'b1;
        enq_vld_d[qi_s][n_s[qi_s][EW-1:0]]  = 1'b1;
        enq_info_d[qi_s][n_s[qi_s][EW-1:0]] = bus.i_disp_info[i];
        n_s[qi_s]                             = n_s[qi_s] + NW'(1);
      end else begin
        ok_s = 1'b0;
      end
    end
  end

  for (genvar q = 0; q < IQ_NUM; q++) begin : g_credit
    assign enq_cnt_s[q] = CW'(n_s[q]);
    iq_credit_ctr #(.DEPTH(IQ_DEPTH), .CW(CW)) u_ctr (
      .clk      (clk),
      .rst      (rst),
      .flush_i  (bus.i_squash_vld),
      .enq_cnt_i(enq_cnt_s[q]),
      .deq_cnt_i(bus.i_iq_deq_cnt[q]),
      .credit_o (credit_s[q])
    );
  end

  // Hand-off register toward the issue queues.
  always_ff @(posedge clk) begin
    if (rst) begin
      enq_vld_q  <= '0;
      enq_info_q <= '0;
    end else begin
      enq_vld_q  <= enq_vld_d;
      enq_info_q <= enq_info_d;
    end
  end

  assign bus.o_disp_rdy    = rdy_s;
  assign bus.o_iq_enq_vld  = enq_vld_q;
  assign bus.o_iq_enq_info = enq_info_q;

`ifdef INT_DISP_ROUTER_PERF_EN
  logic [63:0]             stall_q;
  logic [IQ_NUM-1:0][63:0] iq_full_q;
  logic [QW-1:0]           qi0_s;

  assign qi0_s = iq_id_to_idx(bus.i_disp_info[0].issueQueId);

  // Performance counters survive squash; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q   <= 64'd0;
      iq_full_q <= '0;
    end else begin
      if (bus.i_disp_req[0] && !rdy_s[0]) begin
        stall_q <= stall_q + 64'd1;
      end else begin
        stall_q <= stall_q;
      end
      for (int q = 0; q < IQ_NUM; q++) begin
        if (bus.i_disp_req[0] && !bad_id_s[0] && (qi0_s == QW'(q)) && (credit_s[q] == CW'(0))) begin
          iq_full_q[q] <= iq_full_q[q] + 64'd1;
        end else begin
          iq_full_q[q] <= iq_full_q[q];
        end
      end
    end
  end

  assign o_perf_stall_cycles = stall_q;
  assign o_perf_iq_full      = iq_full_q;
`endif

  int_disp_router_chk #(
    .DISP_WID(DISP_WID), .IQ_NUM(IQ_NUM), .IQ_DEPTH(IQ_DEPTH), .CW(CW)
  ) u_chk (
    .clk      (clk),
    .rst      (rst),
    .squash_i (bus.i_squash_vld),
    .bad_id_i (bad_id_s),
    .rdy_i    (rdy_s),
    .credit_i (credit_s),
    .enq_cnt_i(enq_cnt_s),
    .deq_cnt_i(bus.i_iq_deq_cnt)
  );
endmodule

// File: doc/int_disp_router.md
# int_disp_router

Routes in-order micro-ops from the integer dispatch queue head (up to `DISP_WID` per cycle) into the integer-side issue queues selected by each op's `issueQueId`. The block sits directly downstream of the dispatch stage's integer dispatch queue and upstream of the ALU, BRU, MDU and SCU issue queues. It keeps a per-issue-queue credit counter of free entries. It accepts ops only as an in-order prefix, and it registers the routed ops for a one-cycle hand-off.

## Interface
Parameters:
- `DISP_WID`, 4, dispatch-queue head width (matches `INTDQ_DISP_WID`)
- `IQ_NUM`, 4, number of integer issue queues; valid `issueQueId` range is 0..IQ_NUM-1
- `IQ_DEPTH`, 16, entries per issue queue; initial credit value
- `IQ_ENQ_WID`, 2, maximum enqueues into one issue queue per cycle

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; rst, synchronous, active-high; clock clk
- `i_squash_vld`  in  1  pipeline flush
- `i_disp_req`  in  DISP_WID  head slot valid; in order, slot 0 oldest
- `i_disp_info`  in  microOp_t[DISP_WID]  head micro-ops
- `o_disp_rdy`  out  DISP_WID  slot accepted this cycle (dequeue strobe)
- `o_iq_enq_vld`  out  IQ_NUM×IQ_ENQ_WID  registered enqueue valid per issue-queue port
- `o_iq_enq_info`  out  microOp_t[IQ_NUM][IQ_ENQ_WID]  registered micro-ops
- `i_iq_deq_cnt`  in  IQ_NUM×$clog2(IQ_DEPTH+1)  entries freed by each issue queue this cycle

## Operation
- The credit counter `credit[q]` has width $clog2(IQ_DEPTH+1).
- Acceptance rule for slot i: accept iff all of the following hold.
  - `i_disp_req[i]` is set.
  - Slot i-1 was accepted (or i==0).
  - `q = issueQueId` is less than IQ_NUM.
  - `n_q` is less than IQ_ENQ_WID and less than `credit[q]`, where `n_q` is the number of accepted slots below i that target q.
- `o_disp_rdy` is a contiguous prefix of ones. A blocked slot blocks every younger slot.
- Port assignment: the k-th accepted op to queue q drives port `[q][k]`. Ports fill from index 0 upward with no gaps.
- Credit update: `credit[q] <= credit[q] - enq_cnt[q] + i_iq_deq_cnt[q]`.
  - Acceptance uses only the registered credit. A same-cycle deq does not enable a same-cycle accept.
- Out-of-range `issueQueId`: the slot is blocked, and a simulation assertion fires.
- Squash:
  - In the squash cycle, `o_disp_rdy` is forced to 0.
  - Next cycle, `o_iq_enq_vld` is 0 and every `credit` is IQ_DEPTH. The issue queues flush in the same cycle.
  - `i_iq_deq_cnt` is ignored in the squash cycle.
- Assertions:
  - `credit[q] + i_iq_deq_cnt[q]` never exceeds IQ_DEPTH, checked after subtracting enqueues.
  - `o_disp_rdy` is always a prefix.

## Timing
- Reset: all `credit` = IQ_DEPTH, `o_iq_enq_vld` = 0, `o_iq_enq_info` = 0.
- `o_disp_rdy` is combinational from `i_disp_req`, `i_disp_info` and registered credit. It has no dependence on downstream ready within the cycle.
- Latency is one cycle. An op accepted in cycle t appears on `o_iq_enq_vld` in cycle t+1.
- Credit is reserved in cycle t, so the issue queue must accept unconditionally at t+1. There is no backpressure port.
- Boundary: when credit is 0, every slot targeting that queue is blocked. When credit is 1 and two slots target the same queue, only the older slot is accepted.
- Simultaneous enq and deq on one queue are both applied in one update. Wrap to negative is impossible by construction.

## Configuration
- `INT_DISP_ROUTER_PERF_EN` defined: the block adds a 64-bit `o_perf_stall_cycles` output and a `IQ_NUM`×64-bit `o_perf_iq_full` output.
  - `o_perf_stall_cycles` counts cycles where `i_disp_req[0]` is set and `o_disp_rdy[0]` is 0.
  - `o_perf_iq_full[q]` counts cycles where slot 0 is blocked by queue q's credit.
  - The counters reset on `rst` only, not on squash.
- Not defined: the perf ports and counters are absent, and routing behaviour is identical.

## Structure
- `microOp_t`, the `*IQ_ID` constants and the issue-queue ID-to-index mapping belong in the shared core package / `core_define.svh`.
- Sub-module `iq_credit_ctr` holds one counter per issue queue. It has inputs enq_cnt, deq_cnt and flush, a parameter DEPTH, and outputs the current credit.
- The router itself does the prefix-accept logic, the port-assignment counts and the output register.

## Test plan
- Reset, then 4 ALU ops (q0) with IQ_ENQ_WID=2 → `o_disp_rdy`=0011; next cycle `o_iq_enq_vld[0]`=11; credit[0]=14.
- Ops targeting q0, q1, q0, q2 → rdy=1111; ports [0][0]=slot0, [0][1]=slot2, [1][0]=slot1, [2][0]=slot3.
- Fill q1 to credit 0, then present q1, q0 → rdy=0000; pulse `i_iq_deq_cnt[1]`=1 → rdy=0001 the following cycle, not the same cycle.
- Credit[0]=1 and slots q0, q0, q1 → rdy=0001 (slot 2 is blocked by the prefix rule).
- Squash while credit[2]=5 and requests are pending → rdy=0 that cycle; next cycle credit[2]=16 and enq_vld=0.
- With `INT_DISP_ROUTER_PERF_EN` defined, 10 cycles of q3 full with slot 0 targeting q3 → `o_perf_iq_full[3]`=10 and `o_perf_stall_cycles`=10.
